// File: rtl/updown_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_pkg
// Description : Shared constants for the parametrised up/down counter.
// Revision    : 1.0 - initial release
// ============================================================================
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

endpackage : updown_counter_pkg
`default_nettype wire

// File: rtl/bcd_digit_updown.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_updown
// Description : One decimal digit with parallel increment/decrement paths and
//               carry/borrow outputs for rippling into the next digit.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_updown
    import updown_counter_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       inc,
    input  logic       dec,
    output logic [3:0] digit_inc,
    output logic [3:0] digit_dec,
    output logic       carry,
    output logic       borrow
);

    logic w_at_nine;
    logic w_at_zero;

    // Non-decimal nibbles behave as 9 so a corrupted digit recovers on the next step
    assign w_at_nine = (digit >= BCD_DIGIT_MAX);
    assign w_at_zero = (digit == 4'd0);

    assign carry     = inc & w_at_nine;
    assign borrow    = dec & w_at_zero;
    assign digit_inc = !inc ? digit : (w_at_nine ? 4'd0 : digit + 4'd1);
    assign digit_dec = !dec ? digit : (w_at_zero ? BCD_DIGIT_MAX : digit - 4'd1);

endmodule : bcd_digit_updown
`default_nettype wire

// File: rtl/updown_counter_param.sv
`default_nettype none
// ============================================================================
// Module      : updown_counter_param
// Description : Reversible counter with programmable terminal value, load,
//               hold, wrap/saturate mode and a registered carry/borrow pulse.
//               Define UPDOWN_CNT_BCD_EN to count in packed BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int WIDTH = 16,
`ifdef UPDOWN_CNT_BCD_EN
    parameter logic [WIDTH-1:0] MAX_VAL = {(WIDTH/4){BCD_DIGIT_MAX}},
`else
    parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
`endif
    parameter bit SATURATE = MODE_WRAP
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             s,
    input  logic             hold,
    input  logic             ld,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] cnt,
    output logic             rc,
    output logic             zero
);

    logic [WIDTH-1:0] r_cnt;
    logic             r_rc;

    logic [WIDTH-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_cnt_dec;
    logic [WIDTH-1:0] w_din_digits;
    logic [WIDTH-1:0] w_din_clamped;
    logic [WIDTH-1:0] w_cnt_next;
    logic             w_rc_next;
    logic             w_up_bound;
    logic             w_at_zero;
    logic             w_above_max;

`ifdef UPDOWN_CNT_BCD_EN
    localparam int c_digits = WIDTH / 4;

    logic [c_digits:0] w_carry;
    logic [c_digits:0] w_borrow;

    assign w_carry[0]  = 1'b1;
    assign w_borrow[0] = 1'b1;

    for (genvar gi = 0; gi < c_digits; gi++) begin : g_digit
        bcd_digit_updown u_digit (
            .digit     (r_cnt[4*gi +: 4]),
            .inc       (w_carry[gi]),
            .dec       (w_borrow[gi]),
            .digit_inc (w_cnt_inc[4*gi +: 4]),
            .digit_dec (w_cnt_dec[4*gi +: 4]),
            .carry     (w_carry[gi+1]),
            .borrow    (w_borrow[gi+1])
        );

        assign w_din_digits[4*gi +: 4] = (din[4*gi +: 4] > BCD_DIGIT_MAX) ?
                                         BCD_DIGIT_MAX : din[4*gi +: 4];
    end

    // A borrow out of the top digit means every digit was zero; a carry out
    // means every digit was nine, which can only be at or above the bound.
    assign w_at_zero  = w_borrow[c_digits];
    assign w_up_bound = (r_cnt >= MAX_VAL) | w_carry[c_digits];
`else
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    assign w_cnt_inc    = r_cnt + c_one;
    assign w_cnt_dec    = r_cnt - c_one;
    assign w_din_digits = din;
    assign w_at_zero    = (r_cnt == '0);
    assign w_up_bound   = (r_cnt >= MAX_VAL);
`endif

    assign w_above_max   = (r_cnt > MAX_VAL);
    assign w_din_clamped = (w_din_digits > MAX_VAL) ? MAX_VAL : w_din_digits;

    always_comb begin
        w_cnt_next = r_cnt;
        w_rc_next  = 1'b0;
        if (ld) begin
            w_cnt_next = w_din_clamped;
        end else if (ce && !hold) begin
            if (s == DIR_UP) begin
                if (w_up_bound) begin
                    w_rc_next  = 1'b1;
                    w_cnt_next = (SATURATE == MODE_SAT && !w_above_max) ? r_cnt : '0;
                end else begin
                    w_cnt_next = w_cnt_inc;
                end
            end else begin
                if (w_at_zero) begin
                    w_rc_next  = 1'b1;
                    w_cnt_next = (SATURATE == MODE_SAT) ? r_cnt : MAX_VAL;
                end else if (w_above_max) begin
                    w_cnt_next = MAX_VAL;
                end else begin
                    w_cnt_next = w_cnt_dec;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_rc  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_next;
            r_rc  <= w_rc_next;
        end
    end

    assign cnt  = r_cnt;
    assign rc   = r_rc;
    assign zero = (r_cnt == '0);

endmodule : updown_counter_param
`default_nettype wire
